// File: rtl/assoc_drain.sv
// assoc_drain: key-associative insertion-ordered buffer that drains all entries
// oldest-first through a valid/ready port on request.
`default_nettype none

module assoc_drain #(
  parameter int KEY_WIDTH   = 5,
  parameter int DATA_WIDTH  = 8,
  parameter int BUFFER_SIZE = 16,
  parameter int COUNT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [KEY_WIDTH-1:0]   wr_key,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   start,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [KEY_WIDTH-1:0]   out_key,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   busy,
  output logic                   done,
  output logic                   wr_drop
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] FULL = COUNT_WIDTH'(BUFFER_SIZE);

  state_t                  state;
  logic [BUFFER_SIZE-1:0]  slot_valid;
  logic [KEY_WIDTH-1:0]    slot_key  [BUFFER_SIZE];
  logic [DATA_WIDTH-1:0]   slot_data [BUFFER_SIZE];

  logic [BUFFER_SIZE-1:0]  match;
  logic                    hit;
  logic                    do_insert;
  logic [COUNT_WIDTH-1:0]  count_after_write;

  // Only valid slots take part in the key compare.
  for (genvar i = 0; i < BUFFER_SIZE; i++) begin : g_match
    assign match[i] = slot_valid[i] && (slot_key[i] == wr_key);
  end

  assign hit               = |match;
  assign do_insert         = (state == IDLE) && wr_en && !hit && (count != FULL);
  assign count_after_write = count + {{(COUNT_WIDTH-1){1'b0}}, do_insert};

  assign out_valid = (state == DRAIN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_key   = slot_key[0];
  assign out_data  = slot_data[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      slot_valid <= '0;
      count      <= '0;
      wr_drop    <= 1'b0;
      for (int i = 0; i < BUFFER_SIZE; i++) begin
        slot_key[i]  <= '0;
        slot_data[i] <= '0;
      end
    end else begin
      wr_drop <= wr_en && ((state != IDLE) || (!hit && (count == FULL)));
      case (state)
        IDLE: begin
          if (wr_en && hit) begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
              if (match[i]) slot_data[i] <= wr_data;
            end
          end else if (do_insert) begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
              if (COUNT_WIDTH'(i) == count) begin
                slot_valid[i] <= 1'b1;
                slot_key[i]   <= wr_key;
                slot_data[i]  <= wr_data;
              end
            end
          end
          count <= count_after_write;
          // A same-cycle write is counted before deciding whether anything drains.
          if (start) state <= (count_after_write != '0) ? DRAIN : DONE;
        end
        DRAIN: begin
          if (out_ready) begin
            for (int i = 0; i < BUFFER_SIZE - 1; i++) begin
              slot_valid[i] <= slot_valid[i+1];
              slot_key[i]   <= slot_key[i+1];
              slot_data[i]  <= slot_data[i+1];
            end
            slot_valid[BUFFER_SIZE-1] <= 1'b0;
            slot_key[BUFFER_SIZE-1]   <= '0;
            slot_data[BUFFER_SIZE-1]  <= '0;
            count <= count - 1'b1;
            if (count == {{(COUNT_WIDTH-1){1'b0}}, 1'b1}) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_assoc_drain.sv
// Randomized scoreboard bench for assoc_drain against a queue-based reference model.
`default_nettype none

module tb_assoc_drain;

  typedef struct packed {
    logic [4:0] k;
    logic [7:0] d;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_key = '0;
  logic [7:0] wr_data = '0;
  logic       start = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [4:0] out_key;
  logic [7:0] out_data;
  logic [4:0] count;
  logic       busy;
  logic       done;
  logic       wr_drop;

  int vecs = 0;
  int errs = 0;

  ent_t model[$];   // stored entries, oldest first
  ent_t exp_q[$];   // entries the DUT still owes on its output port

  assoc_drain #(
    .KEY_WIDTH(5), .DATA_WIDTH(8), .BUFFER_SIZE(16), .COUNT_WIDTH(5)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_key(wr_key), .wr_data(wr_data),
    .start(start), .out_ready(out_ready), .out_valid(out_valid), .out_key(out_key),
    .out_data(out_data), .count(count), .busy(busy), .done(done), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: whatever is presented must be the oldest owed entry; pop on handshake.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_out: got key %0h data %0h expected nothing", out_key, out_data);
      end else begin
        chk("out_key", 32'(out_key), 32'(exp_q[0].k));
        chk("out_data", 32'(out_data), 32'(exp_q[0].d));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Reference write rule; returns 1 when the write should be dropped.
  function automatic bit model_write(input logic [4:0] k, input logic [7:0] d);
    ent_t e;
    for (int j = 0; j < model.size(); j++) begin
      if (model[j].k == k) begin
        model[j].d = d;
        return 1'b0;
      end
    end
    if (model.size() >= 16) return 1'b1;
    e.k = k;
    e.d = d;
    model.push_back(e);
    return 1'b0;
  endfunction

  task automatic do_write(input logic [4:0] k, input logic [7:0] d);
    bit drop;
    drop    = model_write(k, d);
    wr_en   = 1'b1;
    wr_key  = k;
    wr_data = d;
    cyc();
    wr_en = 1'b0;
    chk("wr_drop", 32'(wr_drop), 32'(drop));
    chk("count_after_write", 32'(count), 32'(model.size()));
  endtask

  // mode 0: random ready + stray writes, 1: ready held high, 2: ready pattern 1,0,0,1
  task automatic drain(input bit with_w, input logic [4:0] k, input logic [7:0] d, input int mode);
    bit drop;
    bit wen;
    int n;
    int rem;
    int step;
    drop = 1'b0;
    if (with_w) begin
      drop    = model_write(k, d);
      wr_en   = 1'b1;
      wr_key  = k;
      wr_data = d;
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    wr_en = 1'b0;
    if (with_w) chk("start_wr_drop", 32'(wr_drop), 32'(drop));
    n = model.size();
    foreach (model[j]) exp_q.push_back(model[j]);
    model.delete();
    if (n == 0) begin
      chk("empty_done", 32'(done), 32'd1);
      chk("empty_out_valid", 32'(out_valid), 32'd0);
    end else begin
      chk("drain_busy", 32'(busy), 32'd1);
      chk("drain_count", 32'(count), 32'(n));
      rem  = n;
      step = 0;
      while (rem > 0) begin
        case (mode)
          1:       out_ready = 1'b1;
          2:       out_ready = (step % 4 == 0) || (step % 4 == 3);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        wen     = (mode == 0) && ($urandom_range(0, 3) == 0);
        wr_en   = wen;
        wr_key  = 5'($urandom);
        wr_data = 8'($urandom);
        cyc();
        wr_en = 1'b0;
        chk("drain_wr_drop", 32'(wr_drop), 32'(wen));
        if (out_ready) rem--;
        chk("drain_count_step", 32'(count), 32'(rem));
        step++;
      end
      chk("drain_done", 32'(done), 32'd1);
    end
    out_ready = 1'b0;
    cyc();
    chk("done_cleared", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_count", 32'(count), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_drop", 32'(wr_drop), 32'd0);
    chk("rst_out_key", 32'(out_key), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    cyc();
    rst = 1'b1;
    cyc();

    // Basic ordered drain
    do_write(5'd3, 8'h11);
    do_write(5'd7, 8'h22);
    do_write(5'd1, 8'h33);
    drain(1'b0, '0, '0, 1);

    // Overwrite keeps a single entry
    do_write(5'd7, 8'h22);
    do_write(5'd7, 8'h99);
    drain(1'b0, '0, '0, 1);

    // Full buffer: new key dropped, existing key rewritten
    for (int i = 0; i < 16; i++) do_write(5'(i), 8'(i + 8'h40));
    do_write(5'd20, 8'hAA);
    do_write(5'd0, 8'h55);
    drain(1'b0, '0, '0, 0);

    // Back-pressure pattern
    for (int i = 0; i < 5; i++) do_write(5'(i + 10), 8'(i * 3 + 1));
    drain(1'b0, '0, '0, 2);

    // Start on an empty buffer, then a write folded into the start cycle
    drain(1'b0, '0, '0, 1);
    do_write(5'd9, 8'h01);
    drain(1'b1, 5'd12, 8'h77, 1);
    drain(1'b1, 5'd30, 8'h5A, 0);

    // Reset after the second of five transfers
    for (int i = 0; i < 5; i++) do_write(5'(i + 20), 8'(i + 8'hC0));
    start = 1'b1;
    cyc();
    start = 1'b0;
    foreach (model[j]) exp_q.push_back(model[j]);
    model.delete();
    out_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_key", 32'(out_key), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    out_ready = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    do_write(5'd4, 8'h44);
    drain(1'b0, '0, '0, 1);

    // Random rounds
    for (int r = 0; r < 40; r++) begin
      int nw;
      nw = $urandom_range(0, 22);
      for (int w = 0; w < nw; w++) do_write(5'($urandom), 8'($urandom));
      drain(1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire
